// File: rtl/reaction_timer_multi_if.sv
// Interface bundling the reaction timer's button/LED side and its LCD report
// handshake.
// The timer module uses the slave modport. The I/O and LCD side uses the master modport.
// Optional build macro: BEST_TIME_EN adds the BestTime output.
//
// Handshake: LCDUpdate is the valid and LCDAck is the ready. LCDUpdate rises
// when a report is ready and stays high, with the result fields stable, until
// a clock edge at which LCDAck is high. On that edge the report is consumed.
// LCDUpdate falls and the result fields keep their values until the next arm.
interface reaction_timer_multi_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int RT_W        = 10,
   parameter int DELAY_W     = 14,
   parameter int LED_W       = 8
);
   localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

   logic                   Start;
   logic [NUM_PLAYERS-1:0] Btn;
   logic [DELAY_W-1:0]     RandomValue;
   logic                   LCDAck;
   logic [LED_W-1:0]       LED;
   logic [RT_W-1:0]        ReactionTime;
   logic [WIN_W-1:0]       Winner;
   logic                   Cheat;
   logic                   Slow;
   logic                   Wait;
   logic                   LCDUpdate;
   logic [1:0]             state_dbg;   // current FSM state, for observation
`ifdef BEST_TIME_EN
   logic [RT_W-1:0]        BestTime;
`endif

   modport master (
`ifdef BEST_TIME_EN
      input  BestTime,
`endif
      output Start, Btn, RandomValue, LCDAck,
      input  LED, ReactionTime, Winner, Cheat, Slow, Wait, LCDUpdate, state_dbg
   );

   modport slave (
`ifdef BEST_TIME_EN
      output BestTime,
`endif
      input  Start, Btn, RandomValue, LCDAck,
      output LED, ReactionTime, Winner, Cheat, Slow, Wait, LCDUpdate, state_dbg
   );
endinterface

// File: rtl/reaction_timer_multi.sv
// Multi-player reaction timer.
// The timer arms on a Start edge and waits RandomValue ms ticks. It then
// lights the LEDs and times the first player press.
// A press before the LEDs light is reported as a cheat.
// If no press arrives within SLOW_LIMIT ticks, the response is reported as slow.
// Results go to the LCD driver through the LCDUpdate/LCDAck handshake.
// Optional build macro: BEST_TIME_EN keeps the best valid reaction time in BestTime.
module reaction_timer_multi #(
   parameter int NUM_PLAYERS = 2,
   parameter int RT_W        = 10,
   parameter int DELAY_W     = 14,
   parameter int TICK_DIV    = 50000,
   parameter int SLOW_LIMIT  = 500,
   parameter int LED_W       = 8
) (
   input logic                   Clk,
   input logic                   Rst,
   reaction_timer_multi_if.slave io
);
   localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
   localparam logic [RT_W-1:0]    RT_SLOW    = RT_W'(SLOW_LIMIT);
   localparam logic [RT_W-1:0]    RT_SLOW_M1 = RT_W'(SLOW_LIMIT - 1);
   localparam logic [DELAY_W-1:0] DELAY_ONE  = DELAY_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_GO     = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   state_t             state;
   logic [PRE_W-1:0]   presc;
   logic [DELAY_W-1:0] delay;
   logic [RT_W-1:0]    rt;
   logic               start_q;
   logic               tick;
   logic               start_edge;
   logic               any_btn;
   logic [WIN_W-1:0]   first_btn;

   assign tick         = (presc == PRE_LAST);
   assign start_edge   = io.Start & ~start_q;
   assign any_btn      = |io.Btn;
   assign io.state_dbg = state;

   // Find the lowest pressed button index. The downward scan lets the lowest index overwrite the rest.
   always_comb begin
      first_btn = '0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (io.Btn[i]) first_btn = WIN_W'(i);
      end
   end

   // Control FSM with the ms prescaler, delay/rt counters and registered outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state           <= S_IDLE;
         presc           <= '0;
         delay           <= '0;
         rt              <= '0;
         start_q         <= 1'b1;   // a Start held through reset must not look like an edge
         io.LED          <= '0;
         io.ReactionTime <= '0;
         io.Winner       <= '0;
         io.Cheat        <= 1'b0;
         io.Slow         <= 1'b0;
         io.Wait         <= 1'b0;
         io.LCDUpdate    <= 1'b0;
`ifdef BEST_TIME_EN
         io.BestTime     <= '1;
`endif
      end else begin
         start_q <= io.Start;
         presc   <= tick ? '0 : presc + 1'b1;
         case (state)
            S_IDLE: begin
               if (start_edge) begin
                  state           <= S_ARMED;
                  presc           <= '0;
                  delay           <= (io.RandomValue == '0) ? DELAY_ONE : io.RandomValue;
                  io.Cheat        <= 1'b0;
                  io.Slow         <= 1'b0;
                  io.ReactionTime <= '0;
                  io.Winner       <= '0;
                  io.Wait         <= 1'b1;
               end
            end
            S_ARMED: begin
               // A press beats a delay expiring in the same cycle.
               if (any_btn) begin
                  state        <= S_REPORT;
                  io.Cheat     <= 1'b1;
                  io.Winner    <= first_btn;
                  io.Wait      <= 1'b0;
                  io.LCDUpdate <= 1'b1;
               end else if (tick) begin
                  delay <= delay - 1'b1;
                  if (delay == DELAY_ONE) begin
                     state   <= S_GO;
                     presc   <= '0;
                     rt      <= '0;
                     io.LED  <= '1;
                     io.Wait <= 1'b0;
                  end
               end
            end
            S_GO: begin
               // A press beats the slow limit being reached in the same cycle.
               if (any_btn) begin
                  state           <= S_REPORT;
                  io.ReactionTime <= rt;
                  io.Winner       <= first_btn;
                  io.LED          <= '0;
                  io.LCDUpdate    <= 1'b1;
`ifdef BEST_TIME_EN
                  if (rt < io.BestTime) io.BestTime <= rt;
`endif
               end else if (tick) begin
                  rt <= rt + 1'b1;
                  if (rt == RT_SLOW_M1) begin
                     state           <= S_REPORT;
                     io.Slow         <= 1'b1;
                     io.ReactionTime <= RT_SLOW;
                     io.Winner       <= '0;
                     io.LED          <= '0;
                     io.LCDUpdate    <= 1'b1;
                  end
               end
            end
            S_REPORT: begin
               if (io.LCDAck) begin
                  state        <= S_IDLE;
                  io.LCDUpdate <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_reaction_timer_multi.sv
// Testbench for reaction_timer_multi with TICK_DIV=4, SLOW_LIMIT=20 and two players.
// The bench covers directed trials, randomized trials, reset in the middle of a
// game, and Start held high through reset.
// Expected results come from tick arithmetic on cycle counts.
// Build with BEST_TIME_EN defined to also check BestTime.
`timescale 1ns/1ps
module tb_reaction_timer_multi;
   localparam int NP         = 2;
   localparam int RT_W       = 10;
   localparam int DELAY_W    = 14;
   localparam int TICK_DIV   = 4;
   localparam int SLOW_LIMIT = 20;
   localparam int LED_W      = 8;

   // clock / reset
   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   reaction_timer_multi_if #(.NUM_PLAYERS(NP), .RT_W(RT_W), .DELAY_W(DELAY_W), .LED_W(LED_W)) io ();

   reaction_timer_multi #(
      .NUM_PLAYERS(NP), .RT_W(RT_W), .DELAY_W(DELAY_W),
      .TICK_DIV(TICK_DIV), .SLOW_LIMIT(SLOW_LIMIT), .LED_W(LED_W)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .io (io)
   );

   int checks = 0;
   int errors = 0;
   int best   = (1 << RT_W) - 1;   // best valid reaction time seen since reset
   logic [31:0] exp_q[$];          // expected ReactionTime per report

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: inputs set before this call are sampled at the posedge; outputs are read at the negedge
   task automatic cyc();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   function automatic int lowest(input logic [NP-1:0] b);
      for (int i = 0; i < NP; i++) if (b[i]) return i;
      return 0;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_led"},  io.LED, 0);
      check({tag, "_wait"}, io.Wait, 0);
      check({tag, "_cheat"}, io.Cheat, 0);
      check({tag, "_slow"}, io.Slow, 0);
      check({tag, "_rt"},   io.ReactionTime, 0);
      check({tag, "_win"},  io.Winner, 0);
      check({tag, "_upd"},  io.LCDUpdate, 0);
   endtask

   // mode 0: cheat after 'when' armed cycles; 1: press 'when' cycles after GO; 2: no press (slow)
   task automatic run_trial(input int d, input int mode, input int when,
                            input logic [NP-1:0] btns, input int ack_wait);
      int de, t_led, exp_win, exp_cheat, exp_slow;
      logic [31:0] exp_rt;
      de    = (d == 0) ? 1 : d;
      t_led = TICK_DIV * de;
      io.Start = 1'b0;
      cyc();
      io.RandomValue = DELAY_W'(d);
      io.Start = 1'b1;
      cyc();
      io.Start = 1'b0;
      check("arm_wait", io.Wait, 1);
      check("arm_rt_clr", io.ReactionTime, 0);
      check("arm_cheat_clr", io.Cheat, 0);
      check("arm_slow_clr", io.Slow, 0);
      if (mode == 0) begin
         repeat (when) cyc();
         check("armed_led_off", io.LED, 0);
         io.Btn = btns;
         cyc();
         exp_cheat = 1; exp_slow = 0; exp_win = lowest(btns); exp_rt = 0;
      end else begin
         repeat (t_led - 1) cyc();
         check("pre_go_led", io.LED, 0);
         check("pre_go_wait", io.Wait, 1);
         cyc();
         check("go_led", io.LED, 8'hFF);
         check("go_wait", io.Wait, 0);
         if (mode == 1) begin
            repeat (when) cyc();
            check("go_no_report", io.LCDUpdate, 0);
            io.Btn = btns;
            cyc();
            exp_cheat = 0; exp_slow = 0; exp_win = lowest(btns); exp_rt = when / TICK_DIV;
            if (int'(exp_rt) < best) best = exp_rt;
         end else begin
            repeat (TICK_DIV * SLOW_LIMIT - 1) cyc();
            check("pre_slow_upd", io.LCDUpdate, 0);
            check("pre_slow_led", io.LED, 8'hFF);
            cyc();
            exp_cheat = 0; exp_slow = 1; exp_win = 0; exp_rt = SLOW_LIMIT;
         end
      end
      exp_q.push_back(exp_rt);
      // report entry
      check("rep_upd", io.LCDUpdate, 1);
      check("rep_cheat", io.Cheat, exp_cheat);
      check("rep_slow", io.Slow, exp_slow);
      check("rep_win", io.Winner, exp_win);
      check("rep_rt", io.ReactionTime, exp_q.pop_front());
      check("rep_led", io.LED, 0);
      check("rep_wait", io.Wait, 0);
`ifdef BEST_TIME_EN
      check("best_time", io.BestTime, best);
`endif
      io.Btn = '0;
      repeat (ack_wait) begin
         io.Start = 1'($urandom_range(0, 1));   // Start must be ignored in REPORT
         cyc();
         check("rep_hold_upd", io.LCDUpdate, 1);
         check("rep_hold_wait", io.Wait, 0);
      end
      io.Start  = 1'b0;
      io.LCDAck = 1'b1;
      cyc();
      io.LCDAck = 1'b0;
      check("ack_upd", io.LCDUpdate, 0);
      check("ack_rt_hold", io.ReactionTime, exp_rt);
      cyc();
      check("idle_wait", io.Wait, 0);
      check("idle_led", io.LED, 0);
   endtask

   initial begin
      Rst = 1'b1;
      io.Start = 1'b0;
      io.Btn = '0;
      io.RandomValue = '0;
      io.LCDAck = 1'b0;
      repeat (3) cyc();
      check_all_zero("reset");
`ifdef BEST_TIME_EN
      check("reset_best", io.BestTime, (1 << RT_W) - 1);
`endif
      Rst = 1'b0;
      cyc();
      check("post_reset_wait", io.Wait, 0);

      // directed trials
      run_trial(5, 1, 28, 2'b10, 1);   // rt 7, winner 1
      run_trial(3, 1, 12, 2'b11, 0);   // both buttons together at rt 3
      run_trial(2, 1, 38, 2'b01, 2);   // rt 9
      run_trial(4, 0, 5, 2'b01, 1);    // cheat
      run_trial(1, 2, 0, 2'b00, 1);    // slow
      run_trial(2, 0, 7, 2'b10, 0);    // press on the expiry cycle: cheat wins
      run_trial(0, 1, 79, 2'b10, 1);   // zero delay acts as 1; press on limit cycle wins

      // randomized trials
      for (int n = 0; n < 10; n++) begin
         int d, mode, when;
         d    = $urandom_range(0, 6);
         mode = $urandom_range(0, 2);
         when = (mode == 0) ? $urandom_range(0, TICK_DIV * ((d == 0) ? 1 : d) - 1)
                            : $urandom_range(0, TICK_DIV * SLOW_LIMIT - 1);
         run_trial(d, mode, when, NP'($urandom_range(1, 3)), $urandom_range(0, 3));
      end

      // reset in the middle of GO
      io.Start = 1'b0;
      cyc();
      io.RandomValue = DELAY_W'(1);
      io.Start = 1'b1;
      cyc();
      io.Start = 1'b0;
      repeat (TICK_DIV) cyc();
      check("rst_go_led", io.LED, 8'hFF);
      repeat (6) cyc();
      Rst = 1'b1;
      cyc();
      check_all_zero("mid_go_rst");
`ifdef BEST_TIME_EN
      check("mid_go_rst_best", io.BestTime, (1 << RT_W) - 1);
`endif
      best = (1 << RT_W) - 1;

      // Start held high across reset release
      io.Start = 1'b1;
      cyc();
      Rst = 1'b0;
      repeat (5) cyc();
      check("held_start_wait", io.Wait, 0);
      check("held_start_led", io.LED, 0);
      repeat (TICK_DIV) cyc();
      check("held_start_led2", io.LED, 0);

      // normal operation afterwards
      run_trial(2, 1, 17, 2'b01, 1);   // rt 4

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
